emm_arbiter: RTL and testbench

Parametrised N-port pipelined Wishbone B4 arbiter placed between the processor's bus masters (fetch, load/store, debug) and the single external memory master port. It replaces the fixed two-port memory mux with a configurable port count, selectable fixed-priority or round-robin arbitration, and an outstanding-transaction counter. Acks and read data are routed to the granted port, and the grant is held for the whole cycle.

---
 rtl/emm_arbiter_if.sv | 44 ++++
 rtl/emm_arbiter.sv | 148 ++++++++++++++
 tb/tb_emm_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/emm_arbiter_if.sv
// Wishbone B4 pipelined bundle for emm_arbiter: NPORTS upstream ports plus one downstream port.
// The "master" modport is the arbiter's own view: it masters the memory bus.
// The "slave" modport is the environment's view: the bus masters and the memory.
interface emm_arbiter_if #(
    parameter int unsigned NPORTS = 2
);
    logic [NPORTS*32-1:0] s_wb_adr_i;
    logic [NPORTS*32-1:0] s_wb_dat_i;
    logic [NPORTS*32-1:0] s_wb_dat_o;
    logic [NPORTS-1:0]    s_wb_we_i;
    logic [NPORTS*4-1:0]  s_wb_sel_i;
    logic [NPORTS-1:0]    s_wb_stb_i;
    logic [NPORTS-1:0]    s_wb_cyc_i;
    logic [NPORTS-1:0]    s_wb_ack_o;
    logic [NPORTS-1:0]    s_wb_stall_o;

    logic [31:0]          m_wb_adr_o;
    logic [31:0]          m_wb_dat_o;
    logic                 m_wb_we_o;
    logic [3:0]           m_wb_sel_o;
    logic                 m_wb_stb_o;
    logic                 m_wb_cyc_o;
    logic [31:0]          m_wb_dat_i;
    logic                 m_wb_ack_i;
    logic                 m_wb_stall_i;

    logic [NPORTS-1:0]    grant_o;

    modport master (
        input  s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i, s_wb_cyc_i,
        output s_wb_dat_o, s_wb_ack_o, s_wb_stall_o,
        output m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_stb_o, m_wb_cyc_o,
        input  m_wb_dat_i, m_wb_ack_i, m_wb_stall_i,
        output grant_o
    );

    modport slave (
        output s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i, s_wb_cyc_i,
        input  s_wb_dat_o, s_wb_ack_o, s_wb_stall_o,
        input  m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_stb_o, m_wb_cyc_o,
        output m_wb_dat_i, m_wb_ack_i, m_wb_stall_i,
        input  grant_o
    );
endinterface

// File: rtl/emm_arbiter.sv
// N-port pipelined Wishbone B4 arbiter with fixed-priority or round-robin selection.
// The grant is held for a whole cyc; the winning port is passed through combinationally
// and an outstanding-request counter throttles strobes at MAX_OUTSTANDING.
module emm_arbiter #(
    parameter int unsigned NPORTS          = 2,
    parameter int unsigned RR_MODE         = 1,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    emm_arbiter_if.master bus
);

    localparam int unsigned IdxW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   g_q, g_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [NPORTS-1:0] req;
    logic [NPORTS-1:0] cand;
    logic [IdxW-1:0]   winner;
    logic              found;
    logic              release_g;
    logic              full;
    logic              m_stb;
    logic              accept;
    logic              ack_ok;
    int unsigned       idx;
    logic [IdxW-1:0]   idx_w;

    assign req       = bus.s_wb_cyc_i & bus.s_wb_stb_i;
    assign full      = (cnt_q == CntW'(MAX_OUTSTANDING));
    assign release_g = (state_q == StGrant) && !bus.s_wb_cyc_i[g_q];
    assign accept    = m_stb && !bus.m_wb_stall_i;
    // Acks with nothing outstanding (stray or post-abort) are swallowed.
    assign ack_ok    = (state_q == StGrant) && bus.m_wb_ack_i && (cnt_q != '0);

    // Candidate set: the releasing port never re-wins in its own release cycle.
    always_comb begin
        cand = req;
        if (release_g) begin
            cand[g_q] = 1'b0;
        end
    end

    // Winner search: lowest index, or upward from last+1 in round-robin mode.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        idx_w  = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (RR_MODE != 0) begin
                idx = (32'(last_q) + 32'd1 + i) % NPORTS;
            end else begin
                idx = i;
            end
            idx_w = IdxW'(idx);
            if (!found && cand[idx_w]) begin
                winner = idx_w;
                found  = 1'b1;
            end
        end
    end

    // State register: grant FSM, owner index, round-robin pointer, outstanding count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            g_q     <= '0;
            last_q  <= IdxW'(NPORTS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: grant on any request, hand over on cyc drop, count accepts against acks.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (found) begin
                    state_d = StGrant;
                    g_d     = winner;
                    last_d  = winner;
                end
            end
            StGrant: begin
                if (release_g) begin
                    // Dropping cyc abandons anything still outstanding.
                    cnt_d = '0;
                    if (found) begin
                        g_d    = winner;
                        last_d = winner;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (accept && !ack_ok) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!accept && ack_ok) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: pass the granted port through, stall everyone else.
    always_comb begin
        bus.m_wb_adr_o   = '0;
        bus.m_wb_dat_o   = '0;
        bus.m_wb_we_o    = 1'b0;
        bus.m_wb_sel_o   = '0;
        bus.m_wb_cyc_o   = 1'b0;
        bus.s_wb_dat_o   = '0;
        bus.s_wb_ack_o   = '0;
        bus.s_wb_stall_o = '1;
        bus.grant_o      = '0;
        m_stb            = 1'b0;
        if (state_q == StGrant) begin
            bus.grant_o[g_q]          = 1'b1;
            bus.m_wb_adr_o            = bus.s_wb_adr_i[32*g_q +: 32];
            bus.m_wb_dat_o            = bus.s_wb_dat_i[32*g_q +: 32];
            bus.m_wb_we_o             = bus.s_wb_we_i[g_q];
            bus.m_wb_sel_o            = bus.s_wb_sel_i[4*g_q +: 4];
            bus.m_wb_cyc_o            = bus.s_wb_cyc_i[g_q];
            m_stb                     = bus.s_wb_stb_i[g_q] && !full;
            bus.s_wb_stall_o[g_q]     = bus.m_wb_stall_i || full;
            bus.s_wb_ack_o[g_q]       = ack_ok;
            bus.s_wb_dat_o[32*g_q +: 32] = bus.m_wb_dat_i;
        end
        bus.m_wb_stb_o = m_stb;
    end

endmodule

// File: tb/tb_emm_arbiter.sv
// Bench for emm_arbiter: a round-robin and a fixed-priority instance share random stimulus
// and are checked every cycle against a transaction-level model of the arbitration rules.
module tb_emm_arbiter;

    localparam int NP  = 3;
    localparam int MAX = 2;

    logic clk;
    logic rst_ni;

    logic [NP*32-1:0] p_adr, p_dat;
    logic [NP-1:0]    p_we, p_stb, p_cyc;
    logic [NP*4-1:0]  p_sel;
    logic [31:0]      m_dat;
    logic             m_ack, m_stall;

    int nvec = 0;
    int nfail = 0;

    // Model state per instance: 0 = round-robin, 1 = fixed priority.
    bit busy [2];
    int g    [2];
    int last [2];
    int cnt  [2];

    emm_arbiter_if #(.NPORTS(NP)) ifa ();
    emm_arbiter_if #(.NPORTS(NP)) ifb ();

    emm_arbiter #(.NPORTS(NP), .RR_MODE(1), .MAX_OUTSTANDING(MAX)) u_rr (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (ifa)
    );

    emm_arbiter #(.NPORTS(NP), .RR_MODE(0), .MAX_OUTSTANDING(MAX)) u_fp (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (ifb)
    );

    assign ifa.s_wb_adr_i = p_adr;  assign ifb.s_wb_adr_i = p_adr;
    assign ifa.s_wb_dat_i = p_dat;  assign ifb.s_wb_dat_i = p_dat;
    assign ifa.s_wb_we_i  = p_we;   assign ifb.s_wb_we_i  = p_we;
    assign ifa.s_wb_sel_i = p_sel;  assign ifb.s_wb_sel_i = p_sel;
    assign ifa.s_wb_stb_i = p_stb;  assign ifb.s_wb_stb_i = p_stb;
    assign ifa.s_wb_cyc_i = p_cyc;  assign ifb.s_wb_cyc_i = p_cyc;
    assign ifa.m_wb_dat_i = m_dat;  assign ifb.m_wb_dat_i = m_dat;
    assign ifa.m_wb_ack_i = m_ack;  assign ifb.m_wb_ack_i = m_ack;
    assign ifa.m_wb_stall_i = m_stall;
    assign ifb.m_wb_stall_i = m_stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input logic [127:0] act,
                       input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, k, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [NP-1:0] r, input int lst, input bit rr);
        if (rr) begin
            for (int i = 1; i <= NP; i++) begin
                if (r[(lst + i) % NP]) return (lst + i) % NP;
            end
        end else begin
            for (int j = 0; j < NP; j++) begin
                if (r[j]) return j;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            busy[k] = 1'b0;
            g[k]    = 0;
            last[k] = NP - 1;
            cnt[k]  = 0;
        end
    endtask

    task automatic model_step();
        logic [NP-1:0] r;
        bit acc, ak;
        for (int k = 0; k < 2; k++) begin
            r = p_cyc & p_stb;
            if (!busy[k]) begin
                cnt[k] = 0;
                if (r != '0) begin
                    busy[k] = 1'b1;
                    g[k]    = pick(r, last[k], k == 0);
                    last[k] = g[k];
                end
            end else if (!p_cyc[g[k]]) begin
                cnt[k]  = 0;
                r[g[k]] = 1'b0;
                if (r != '0) begin
                    g[k]    = pick(r, last[k], k == 0);
                    last[k] = g[k];
                end else begin
                    busy[k] = 1'b0;
                end
            end else begin
                acc    = p_stb[g[k]] && (cnt[k] != MAX) && !m_stall;
                ak     = m_ack && (cnt[k] > 0);
                cnt[k] = cnt[k] + (acc ? 1 : 0) - (ak ? 1 : 0);
            end
        end
    endtask

    // Model advances on the same events as the DUT state.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_ni);
            if (!rst_ni) model_reset();
            else         model_step();
        end
    end

    task automatic compare_inst(input int k);
        logic [NP-1:0]    eg, est, eak, ag, ast, aak;
        logic [NP*32-1:0] edo, ado;
        logic [31:0]      ead, edt, aad, adt;
        logic [3:0]       esl, asl;
        logic             ewe, estb, ecyc, awe, astb, acyc;
        bit               full;
        eg = '0; est = '1; eak = '0; edo = '0; ead = '0; edt = '0; esl = '0;
        ewe = 1'b0; estb = 1'b0; ecyc = 1'b0;
        if (busy[k]) begin
            full              = (cnt[k] == MAX);
            eg[g[k]]          = 1'b1;
            ead               = p_adr[32*g[k] +: 32];
            edt               = p_dat[32*g[k] +: 32];
            esl               = p_sel[4*g[k] +: 4];
            ewe               = p_we[g[k]];
            ecyc              = p_cyc[g[k]];
            estb              = p_stb[g[k]] && !full;
            est[g[k]]         = m_stall || full;
            eak[g[k]]         = m_ack && (cnt[k] > 0);
            edo[32*g[k] +: 32] = m_dat;
        end
        if (k == 0) begin
            ag = ifa.grant_o; ast = ifa.s_wb_stall_o; aak = ifa.s_wb_ack_o; ado = ifa.s_wb_dat_o;
            aad = ifa.m_wb_adr_o; adt = ifa.m_wb_dat_o; asl = ifa.m_wb_sel_o;
            awe = ifa.m_wb_we_o; astb = ifa.m_wb_stb_o; acyc = ifa.m_wb_cyc_o;
        end else begin
            ag = ifb.grant_o; ast = ifb.s_wb_stall_o; aak = ifb.s_wb_ack_o; ado = ifb.s_wb_dat_o;
            aad = ifb.m_wb_adr_o; adt = ifb.m_wb_dat_o; asl = ifb.m_wb_sel_o;
            awe = ifb.m_wb_we_o; astb = ifb.m_wb_stb_o; acyc = ifb.m_wb_cyc_o;
        end
        chk("grant", k, 128'(ag), 128'(eg));
        chk("s_stall", k, 128'(ast), 128'(est));
        chk("s_ack", k, 128'(aak), 128'(eak));
        chk("s_dat_o", k, 128'(ado), 128'(edo));
        chk("m_adr", k, 128'(aad), 128'(ead));
        chk("m_dat_o", k, 128'(adt), 128'(edt));
        chk("m_sel", k, 128'(asl), 128'(esl));
        chk("m_we", k, 128'(awe), 128'(ewe));
        chk("m_stb", k, 128'(astb), 128'(estb));
        chk("m_cyc", k, 128'(acyc), 128'(ecyc));
    endtask

    // Per-cycle comparison on the falling edge, away from state updates.
    initial begin
        forever begin
            @(negedge clk);
            compare_inst(0);
            compare_inst(1);
        end
    end

    task automatic randomize_ports();
        for (int j = 0; j < NP; j++) begin
            if (p_cyc[j]) begin
                if ($urandom_range(5) == 0) p_cyc[j] = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                p_cyc[j] = 1'b1;
            end
            p_stb[j]            = p_cyc[j] && ($urandom_range(9) < 6);
            p_adr[32*j +: 32]   = $urandom;
            p_dat[32*j +: 32]   = $urandom;
            p_sel[4*j +: 4]     = 4'($urandom);
            p_we[j]             = 1'($urandom);
        end
        m_ack   = ($urandom_range(9) < 3);
        m_stall = ($urandom_range(9) < 2);
        m_dat   = $urandom;
    endtask

    initial begin
        rst_ni = 1'b0;
        p_adr = '0; p_dat = '0; p_we = '0; p_sel = '0; p_stb = '0; p_cyc = '0;
        m_dat = 32'h0; m_ack = 1'b0; m_stall = 1'b0;

        // Reset values while reset is held.
        #2;
        chk("rst_grant", 0, 128'(ifa.grant_o), 128'(3'b000));
        chk("rst_stall", 0, 128'(ifa.s_wb_stall_o), 128'(3'b111));
        chk("rst_mcyc", 0, 128'(ifa.m_wb_cyc_o), 128'(1'b0));
        @(negedge clk);
        rst_ni = 1'b1;

        // All three request: not granted until the next edge, then port 0.
        @(posedge clk); #1;
        p_cyc = 3'b111; p_stb = 3'b111;
        #1;
        chk("pre_grant", 0, 128'(ifa.grant_o), 128'(3'b000));
        chk("pre_stall", 0, 128'(ifa.s_wb_stall_o), 128'(3'b111));
        @(posedge clk); #1;
        chk("grant0", 0, 128'(ifa.grant_o), 128'(3'b001));
        chk("grant0", 1, 128'(ifb.grant_o), 128'(3'b001));
        chk("stall0", 0, 128'(ifa.s_wb_stall_o), 128'(3'b110));
        p_cyc[0] = 1'b0; p_stb[0] = 1'b0;

        // Handover straight to port 1 in both modes.
        @(posedge clk); #1;
        chk("grant1", 0, 128'(ifa.grant_o), 128'(3'b010));
        chk("grant1", 1, 128'(ifb.grant_o), 128'(3'b010));
        chk("hand_cyc", 0, 128'(ifa.m_wb_cyc_o), 128'(1'b1));
        p_cyc = 3'b101; p_stb = 3'b101;

        // Round-robin moves on to 2, fixed priority falls back to 0.
        @(posedge clk); #1;
        chk("grant2", 0, 128'(ifa.grant_o), 128'(3'b100));
        chk("grant2", 1, 128'(ifb.grant_o), 128'(3'b001));

        // Asynchronous reset between edges takes effect immediately.
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_grant", 0, 128'(ifa.grant_o), 128'(3'b000));
        chk("arst_grant", 1, 128'(ifb.grant_o), 128'(3'b000));
        chk("arst_mcyc", 0, 128'(ifa.m_wb_cyc_o), 128'(1'b0));
        chk("arst_stall", 0, 128'(ifa.s_wb_stall_o), 128'(3'b111));
        #2 rst_ni = 1'b1;

        // Pointer back at NPORTS-1 after reset, so port 0 wins again.
        @(posedge clk); #1;
        chk("post_rst_grant", 0, 128'(ifa.grant_o), 128'(3'b001));

        // Two accepts without acks fill the counter (MAX=2).
        @(posedge clk);
        @(posedge clk); #1;
        chk("full_stb", 0, 128'(ifa.m_wb_stb_o), 128'(1'b0));
        chk("full_stall", 0, 128'(ifa.s_wb_stall_o), 128'(3'b111));
        m_ack = 1'b1; m_dat = 32'h0000_0011;
        #1;
        chk("ack_fwd", 0, 128'(ifa.s_wb_ack_o), 128'(3'b001));
        chk("dat_fwd", 0, 128'(ifa.s_wb_dat_o), 128'(96'h11));
        @(posedge clk); #1;
        m_ack = 1'b0;
        #1;
        chk("one_more_stb", 0, 128'(ifa.m_wb_stb_o), 128'(1'b1));
        @(posedge clk); #1;
        chk("refull_stb", 0, 128'(ifa.m_wb_stb_o), 128'(1'b0));

        // Abort with outstanding requests; a late ack in IDLE is swallowed.
        p_cyc = '0; p_stb = '0;
        @(posedge clk); #1;
        m_ack = 1'b1;
        #1;
        chk("late_ack", 0, 128'(ifa.s_wb_ack_o), 128'(3'b000));
        chk("late_grant", 0, 128'(ifa.grant_o), 128'(3'b000));
        m_ack = 1'b0;

        // Random phase with occasional mid-cycle asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            randomize_ports();
            if (i % 700 == 350) begin
                #1 rst_ni = 1'b0;
                #4 rst_ni = 1'b1;
            end
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
